// File: rtl/clock_divider_multi.sv
// Multi-channel run-time programmable clock divider with 50% divided clock and tick strobe per channel.
// All outputs registered (one clk after the deciding edge); no flow control, writes are fire-and-forget.
module clock_divider_multi #(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 9,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [DIV_W-1:0]  div_in,
  input  logic [CH_W-1:0]   div_sel,
  input  logic              div_wr,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] sh_q, sh_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             wr_hit;
    logic             terminal;

    // Out-of-range selects never match any channel index, so they are dropped here.
    assign wr_hit   = div_wr && (div_sel == CH_W'(i));
    assign terminal = (cnt_q == act_q);

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      sh_d   = sh_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      pend_d = pend_q;
      if (sync) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        act_d  = wr_hit ? div_in : sh_q;
        sh_d   = wr_hit ? div_in : sh_q;
        pend_d = 1'b0;
      end else if (!en[i]) begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (wr_hit) begin
          act_d  = div_in;
          sh_d   = div_in;
          pend_d = 1'b0;
        end
      end else begin
        if (terminal) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = 1'b1;
          act_d  = sh_q;
          pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A write coinciding with a terminal lands in shadow and waits one more period.
        if (wr_hit) begin
          sh_d   = div_in;
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DEF_DIV;
        sh_q   <= DEF_DIV;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        sh_q   <= sh_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
      end
    end

    assign clk_div[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios then random traffic, checked every cycle
// against a deadline-based reference model; a 3-channel instance exercises out-of-range selects.
module tb_clock_divider_multi;

  localparam int NCH = 4;
  localparam int DEF = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic [7:0]     div_in = '0;
  logic [1:0]     div_sel = '0;
  logic           div_wr = 1'b0;
  logic           sync = 1'b0;
  logic [NCH-1:0] clk_div, tick, pending;
  logic [2:0]     clk_div3, tick3, pending3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clock_divider_multi #(.NUM_CH(NCH), .DIV_W(8), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in), .div_sel(div_sel),
    .div_wr(div_wr), .sync(sync), .clk_div(clk_div), .tick(tick), .pending(pending));

  clock_divider_multi #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(DEF)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en[2:0]), .div_in(div_in), .div_sel(div_sel),
    .div_wr(div_wr), .sync(sync), .clk_div(clk_div3), .tick(tick3), .pending(pending3));

  // Reference model: each channel remembers the absolute edge index of its next terminal.
  int cyc = 0;
  int m_act[NCH], m_sh[NCH], m_dl[NCH];
  bit m_pend[NCH], m_clk[NCH], m_tick[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      m_dl[c] = cyc + DEF + 1;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      wr = div_wr && (int'(div_sel) == c);
      if (sync) begin
        m_act[c] = wr ? int'(div_in) : m_sh[c];
        m_sh[c] = m_act[c];
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        m_dl[c] = cyc + m_act[c] + 1;
      end else if (!en[c]) begin
        if (wr) begin
          m_act[c] = int'(div_in); m_sh[c] = int'(div_in); m_pend[c] = 0;
        end
        m_clk[c] = 0; m_tick[c] = 0;
        m_dl[c] = cyc + m_act[c] + 1;
      end else begin
        if (cyc == m_dl[c]) begin
          m_clk[c] = !m_clk[c]; m_tick[c] = 1;
          m_act[c] = m_sh[c]; m_pend[c] = 0;
          m_dl[c] = cyc + m_act[c] + 1;
        end else begin
          m_tick[c] = 0;
        end
        if (wr) begin
          m_sh[c] = int'(div_in); m_pend[c] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ec, et, ep;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    chk("clk_div", 32'(clk_div), 32'(ec));
    chk("tick", 32'(tick), 32'(et));
    chk("pending", 32'(pending), 32'(ep));
    chk("clk_div3", 32'(clk_div3), 32'(ec[2:0]));
    chk("tick3", 32'(tick3), 32'(et[2:0]));
    chk("pending3", 32'(pending3), 32'(ep[2:0]));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < 300);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_clk_div", 32'(clk_div), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_pending", 32'(pending), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, guard, last_t, t0;
    logic prev;

    // 1: reset state, then channel 0 alone at the default divisor.
    model_reset();
    #1;
    chk("reset_clk_div", 32'(clk_div), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    step();
    rst_n = 1'b1;
    en = 4'b0001;
    prev = 1'b0; last_t = -1; t0 = 0;
    for (int k = 0; k < 45; k++) begin
      step();
      if (clk_div[0] !== prev) begin
        if (last_t >= 0) chk("t1_toggle_interval", 32'(cyc - last_t), 32'd10);
        else t0 = k + 1;
        last_t = cyc;
        prev = clk_div[0];
      end
    end
    chk("t1_first_toggle_edge", 32'(t0), 32'd10);

    // 2: divisor 0 written to disabled channel 1, then enabled.
    div_wr = 1'b1; div_sel = 2'd1; div_in = 8'd0;
    step();
    div_wr = 1'b0;
    en = 4'b0011;
    prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_tick1_high", 32'(tick[1]), 32'd1);
      chk("t2_clk1_toggles", 32'(clk_div[1]), 32'(!prev));
      prev = clk_div[1];
    end

    // 3: mid-period write on channel 0 (D=9) at cnt=5.
    guard = 0;
    while ((m_dl[0] - cyc) != 5 && guard < 40) begin step(); guard++; end
    chk("t3_align_timeout", 32'(guard < 40), 32'd1);
    div_wr = 1'b1; div_sel = 2'd0; div_in = 8'd3;
    step();
    div_wr = 1'b0;
    chk("t3_pending_set", 32'(pending[0]), 32'd1);
    wait_tick(0, n);
    chk("t3_old_period_tail", 32'(n), 32'd4);
    chk("t3_pending_clear", 32'(pending[0]), 32'd0);
    wait_tick(0, n);
    chk("t3_new_period", 32'(n), 32'd4);

    // 4: write on the exact terminal edge.
    guard = 0;
    while ((m_dl[0] - cyc) != 1 && guard < 40) begin step(); guard++; end
    chk("t4_align_timeout", 32'(guard < 40), 32'd1);
    div_wr = 1'b1; div_sel = 2'd0; div_in = 8'd6;
    step();
    div_wr = 1'b0;
    chk("t4_tick_on_write", 32'(tick[0]), 32'd1);
    chk("t4_pending_kept", 32'(pending[0]), 32'd1);
    wait_tick(0, n);
    chk("t4_old_divisor_period", 32'(n), 32'd4);
    chk("t4_pending_clear", 32'(pending[0]), 32'd0);
    wait_tick(0, n);
    chk("t4_new_divisor_period", 32'(n), 32'd7);

    // 5: sync with D=2 and D=4 running and a pending divisor on channel 3.
    en = 4'b1001;
    div_wr = 1'b1; div_sel = 2'd1; div_in = 8'd2; step();
    div_sel = 2'd2; div_in = 8'd4; step();
    div_sel = 2'd3; div_in = 8'd5; step();
    div_wr = 1'b0;
    en = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    chk("t5_pending3_before", 32'(pending[3]), 32'd1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t5_sync_clk_div", 32'(clk_div), 32'd0);
    chk("t5_sync_tick", 32'(tick), 32'd0);
    chk("t5_sync_pending", 32'(pending), 32'd0);
    wait_tick(1, n);
    chk("t5_ch1_realign", 32'(n), 32'd3);
    wait_tick(2, n);
    chk("t5_ch2_realign", 32'(n), 32'd2);

    // 6: disable with a write to select 3 (out of range for the 3-channel instance), then async reset.
    en = 4'b0000;
    div_wr = 1'b1; div_sel = 2'd3; div_in = 8'd1;
    step();
    div_wr = 1'b0;
    chk("t6_en0_clk_div", 32'(clk_div), 32'd0);
    en = 4'b1111;
    for (int k = 0; k < 3; k++) step();
    do_reset();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : en;
      div_wr = ($urandom_range(0, 7) == 0);
      div_sel = 2'($urandom);
      div_in = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      sync = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    div_wr = 1'b0; sync = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
